// File: rtl/uart_tx_fifo.sv
// Purpose : buffered UART transmitter; FIFO feeds a start/data/parity/stop serialiser.
// Latency : push in cycle N -> popped in N+1 -> start bit on o_tx from N+2; frames back-to-back.
// Backpr. : o_ready = !full from registered pointers only; a full FIFO refuses pushes even on a pop.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   i_data/i_valid    word to send; accepted when i_valid && o_ready
//   o_ready           FIFO has space
//   o_tx              serial line, idle high
//   o_busy            serialiser mid-frame
//   o_count           words buffered (excluding the one being shifted out)
//   o_idle            nothing buffered and nothing in flight
module uart_tx_fifo #(
    parameter int clocks_per_bit = 80000,
    parameter int data_bits      = 8,
    parameter int parity_mode    = 0,
    parameter int stop_bits      = 1,
    parameter int fifo_depth     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [data_bits-1:0]          i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(fifo_depth):0]   o_count,
    output logic                          o_idle
);

    localparam int AW = $clog2(fifo_depth);
    localparam int CW = (clocks_per_bit > 2) ? $clog2(clocks_per_bit) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(clocks_per_bit - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [3:0]    DATA_LAST = 4'(data_bits - 1);
    localparam logic [3:0]    STOP_LAST = 4'(stop_bits - 1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO: pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [data_bits-1:0] mem [fifo_depth];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [data_bits-1:0] head;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = i_valid && !full;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    state_t               state, state_n;
    logic [CW-1:0]        baud_cnt, baud_n;
    logic [3:0]           bit_idx, bit_n;      // data bit index, reused as stop-bit index
    logic [data_bits-1:0] shift_q, shift_n;
    logic                 par_q, par_n;
    logic                 par_calc;
    logic                 baud_done;

    // Odd mode: parity = inverted XOR so data+parity has an odd count of ones.
    assign par_calc  = (parity_mode == 1) ? ~(^head) : (^head);
    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shift_q  <= shift_n;
            par_q    <= par_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt + BAUD_ONE;
        bit_n   = bit_idx;
        shift_n = shift_q;
        par_n   = par_q;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    par_n   = par_calc;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_n  = '0;
                    shift_n = shift_q >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = (parity_mode != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_n = bit_idx + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_n = '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_n = head;
                            par_n   = par_calc;
                            state_n = S_START;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_n = bit_idx + 4'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Line level is decoded from registered state only.
    always_comb begin
        o_tx = 1'b1;
        case (state)
            S_START:  o_tx = 1'b0;
            S_DATA:   o_tx = shift_q[0];
            S_PARITY: o_tx = par_q;
            default:  o_tx = 1'b1;
        endcase
    end

    assign o_ready = !full;
    assign o_busy  = (state != S_IDLE);
    assign o_count = wr_ptr - rd_ptr;
    assign o_idle  = !o_busy && empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 7E2, 7O2) at 4 clocks per bit, FIFO depth 4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Cycle c in each task is relative to the cycle in which its first word is presented.
module tb_uart_tx_fifo;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready, a_tx, a_busy, a_idle;
    logic [2:0] a_count;
    logic [6:0] p_data;
    logic       p_valid;
    logic       b_ready, b_tx, b_busy, b_idle;
    logic [2:0] b_count;
    logic       c_ready, c_tx, c_busy, c_idle;
    logic [2:0] c_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] words [20];
    int         nwords;

    uart_tx_fifo #(.clocks_per_bit(4), .data_bits(8), .parity_mode(0), .stop_bits(1), .fifo_depth(4)) dut_a (
        .clock(clock), .reset(reset), .i_data(a_data), .i_valid(a_valid), .o_ready(a_ready),
        .o_tx(a_tx), .o_busy(a_busy), .o_count(a_count), .o_idle(a_idle));

    uart_tx_fifo #(.clocks_per_bit(4), .data_bits(7), .parity_mode(2), .stop_bits(2), .fifo_depth(4)) dut_b (
        .clock(clock), .reset(reset), .i_data(p_data), .i_valid(p_valid), .o_ready(b_ready),
        .o_tx(b_tx), .o_busy(b_busy), .o_count(b_count), .o_idle(b_idle));

    uart_tx_fifo #(.clocks_per_bit(4), .data_bits(7), .parity_mode(1), .stop_bits(2), .fifo_depth(4)) dut_c (
        .clock(clock), .reset(reset), .i_data(p_data), .i_valid(p_valid), .o_ready(c_ready),
        .o_tx(c_tx), .o_busy(c_busy), .o_count(c_count), .o_idle(c_idle));

    // Expected 8N1 line level in cycle c for words[0..nwords-1] sent contiguously,
    // the first start bit beginning at c=2 and each frame lasting 40 cycles.
    function automatic logic exp_a_tx(int c);
        logic [9:0] frame;
        int f;
        if (c < 2 || c >= 2 + 40 * nwords) return 1'b1;
        f = (c - 2) / 40;
        frame = {1'b1, words[f], 1'b0};
        return frame[((c - 2) % 40) / 4];
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; a_valid = 1'b0; a_data = '0; p_valid = 1'b0; p_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            checks++;
            if ({a_tx, a_ready, a_count, a_idle, a_busy} !== 7'b1_1_000_1_0) begin
                errors++;
                $display("FAIL reset_idle_a cycle %0d: got tx,rdy,cnt,idle,busy=%b expected 1100010", i,
                         {a_tx, a_ready, a_count, a_idle, a_busy});
            end
            checks++;
            if ({b_tx, b_ready, b_count, b_idle, c_tx, c_idle} !== 8'b1_1_000_1_1_1) begin
                errors++;
                $display("FAIL reset_idle_bc cycle %0d: got %b expected 11000111", i,
                         {b_tx, b_ready, b_count, b_idle, c_tx, c_idle});
            end
            next_cycle();
        end
    endtask

    task automatic test_single_8n1();
        logic exp_busy, exp_idle;
        logic [2:0] exp_cnt;
        words[0] = 8'h55; nwords = 1;
        for (int c = 0; c < 44; c++) begin
            a_valid = (c == 0);
            a_data  = 8'h55;
            @(negedge clock);
            exp_busy = (c >= 2 && c <= 41);
            exp_idle = (c == 0 || c >= 42);
            exp_cnt  = (c == 1) ? 3'd1 : 3'd0;
            checks++;
            if ({a_tx, a_busy, a_idle, a_count} !== {exp_a_tx(c), exp_busy, exp_idle, exp_cnt}) begin
                errors++;
                $display("FAIL single_8n1 cycle %0d: got tx,busy,idle,cnt=%b expected %b", c,
                         {a_tx, a_busy, a_idle, a_count}, {exp_a_tx(c), exp_busy, exp_idle, exp_cnt});
            end
            next_cycle();
        end
        a_valid = 1'b0;
    endtask

    task automatic test_parity_stop();
        // LSB first: start, data 0x03 (1,1,0,0,0,0,0), parity, two stop bits.
        logic [10:0] frame_even;
        logic [10:0] frame_odd;
        logic eb, ob, exp_busy;
        frame_even = 11'h606;
        frame_odd  = 11'h706;
        for (int c = 0; c < 48; c++) begin
            p_valid = (c == 0);
            p_data  = 7'h03;
            @(negedge clock);
            if (c < 2 || c >= 46) begin
                eb = 1'b1; ob = 1'b1;
            end else begin
                eb = frame_even[(c - 2) / 4];
                ob = frame_odd[(c - 2) / 4];
            end
            exp_busy = (c >= 2 && c <= 45);
            checks++;
            if ({b_tx, b_busy} !== {eb, exp_busy}) begin
                errors++;
                $display("FAIL parity_even cycle %0d: got tx,busy=%b expected %b", c, {b_tx, b_busy}, {eb, exp_busy});
            end
            checks++;
            if ({c_tx, c_busy} !== {ob, exp_busy}) begin
                errors++;
                $display("FAIL parity_odd cycle %0d: got tx,busy=%b expected %b", c, {c_tx, c_busy}, {ob, exp_busy});
            end
            next_cycle();
        end
        p_valid = 1'b0;
    endtask

    task automatic test_fill_backpressure();
        int  idx = 0;
        int  acc5_cycle = -1;
        logic acc, exp_rdy;
        words[0] = 8'hA1; words[1] = 8'h3C; words[2] = 8'hF0;
        words[3] = 8'h0F; words[4] = 8'h5A; words[5] = 8'hC3;
        nwords = 6;
        for (int c = 0; c < 245; c++) begin
            a_valid = (idx < 6);
            a_data  = words[idx];
            @(negedge clock);
            acc = a_valid && a_ready;
            exp_rdy = !((c >= 5 && c <= 41) || (c >= 43 && c <= 81));
            checks++;
            if ({a_tx, a_ready} !== {exp_a_tx(c), exp_rdy}) begin
                errors++;
                $display("FAIL fill_stream cycle %0d: got tx,rdy=%b expected %b", c, {a_tx, a_ready}, {exp_a_tx(c), exp_rdy});
            end
            if (c == 10) begin
                checks++;
                if ({a_count, idx[3:0]} !== {3'd4, 4'd5}) begin
                    errors++;
                    $display("FAIL fill_full: got cnt=%0d accepted=%0d expected cnt=4 accepted=5", a_count, idx);
                end
            end
            if (c == 241 || c == 242) begin
                checks++;
                if ({a_busy, a_idle} !== ((c == 241) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL fill_end cycle %0d: got busy,idle=%b expected %b", c, {a_busy, a_idle},
                             (c == 241) ? 2'b10 : 2'b01);
                end
            end
            if (acc && idx == 5) acc5_cycle = c;
            @(posedge clock);
            if (acc) idx++;
            #1;
        end
        a_valid = 1'b0;
        checks++;
        if (acc5_cycle != 42 || idx != 6) begin
            errors++;
            $display("FAIL fill_sixth_accept: got cycle=%0d accepted=%0d expected cycle=42 accepted=6", acc5_cycle, idx);
        end
    endtask

    task automatic test_wrap_stream();
        int wi;
        logic [2:0] exp_cnt;
        for (int k = 0; k < 20; k++) words[k] = 8'(k * 37 + 11);
        nwords = 20;
        for (int c = 0; c < 804; c++) begin
            // word 0 at c=0, then word k+1 at c=1+40k, coinciding with the pop of word k
            a_valid = (c == 0) || (c >= 1 && (c - 1) % 40 == 0 && (c - 1) / 40 < 19);
            wi      = (c == 0) ? 0 : ((c - 1) / 40 + 1);
            a_data  = words[wi % 20];
            @(negedge clock);
            exp_cnt = (c >= 1 && c <= 761) ? 3'd1 : 3'd0;
            checks++;
            if ({a_tx, a_count} !== {exp_a_tx(c), exp_cnt}) begin
                errors++;
                $display("FAIL wrap_stream cycle %0d: got tx=%b cnt=%0d expected tx=%b cnt=%0d", c, a_tx, a_count,
                         exp_a_tx(c), exp_cnt);
            end
            if (a_valid) begin
                checks++;
                if (a_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_ready cycle %0d: got %b expected 1", c, a_ready);
                end
            end
            next_cycle();
        end
        a_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (a_idle !== 1'b1) begin
            errors++;
            $display("FAIL wrap_idle: got %b expected 1", a_idle);
        end
        next_cycle();
    endtask

    task automatic test_midframe_reset();
        for (int c = 0; c < 113; c++) begin
            a_valid = (c < 4);
            a_data  = 8'h80 + 8'(c);
            reset   = (c == 12);
            @(negedge clock);
            if (c == 11) begin
                checks++;
                if ({a_busy, a_count} !== {1'b1, 3'd3}) begin
                    errors++;
                    $display("FAIL midreset_before: got busy=%b cnt=%0d expected busy=1 cnt=3", a_busy, a_count);
                end
            end
            if (c == 13) begin
                checks++;
                if ({a_tx, a_count, a_busy, a_ready, a_idle} !== 7'b1_000_0_1_1) begin
                    errors++;
                    $display("FAIL midreset_after: got tx,cnt,busy,rdy,idle=%b expected 1000011",
                             {a_tx, a_count, a_busy, a_ready, a_idle});
                end
            end
            if (c > 13) begin
                checks++;
                if ({a_tx, a_busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL midreset_quiet cycle %0d: got tx,busy=%b expected 10", c, {a_tx, a_busy});
                end
            end
            next_cycle();
        end
        reset = 1'b0;
        a_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_8n1();
        test_parity_stop();
        test_fill_backpressure();
        test_wrap_stream();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
